dff_bist: RTL and testbench
===========================

# dff_bist

Built-in self-test initiator for a single D flip-flop cell. It drives the cell's D and active-low reset, samples its Q, and tallies pass/fail results. It sits beside the flip-flop under test in the Task240 delay-characterisation designs, so the cell can be exercised on silicon or in gate-level simulation without a behavioural testbench.

## Interface
- NUM_VECTORS, 8: number of pseudo-random data vectors per run (1..255)
- RST_CYCLES, 2: cycles the DUT reset is held low in the reset phase (≥1)
- SEED, 8'hA5: LFSR seed loaded on start. 0 is illegal; 8'h01 is substituted.
- CNT_W, 8: width of the pass/fail counters
- CLK  input  1  single clock, rising-edge active
- n_res  input  1  asynchronous, active-low reset
- start  input  1  request a run; sampled in IDLE only
- dut_q  input  1  Q from the flip-flop under test
- dut_d  output  1  D to the flip-flop under test (registered)
- dut_n_res  output  1  active-low reset to the flip-flop under test (registered)
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at end of run
- pass_cnt  output  CNT_W  number of checks that matched
- fail_cnt  output  CNT_W  number of checks that mismatched

## Operation
- Reset values: FSM=IDLE, dut_d=0, dut_n_res=1, busy=0, done=0, pass_cnt=0, fail_cnt=0, LFSR=SEED, vector index=0.
- LFSR: 8-bit Fibonacci, l <= {l[6:0], l[7]^l[5]^l[4]^l[3]}. Driven bit = l[0]. Advances on the edge leaving SAMPLE.
- IDLE: dut_n_res=1, dut_d holds. If start=1, the next edge loads LFSR=SEED, clears both counters and the index, and enters DRIVE.
- DRIVE, 1 cycle: dut_d=l[0]. The edge leaving DRIVE is the edge on which the DUT captures.
- SAMPLE, 1 cycle: dut_d held. The edge leaving SAMPLE compares dut_q with the expected bit and increments pass_cnt or fail_cnt. Then:
  - if index < NUM_VECTORS-1: increment index, go to DRIVE;
  - else: go to ARM (macro on) or DONE (macro off).
- ARM, 1 cycle: dut_d=1, dut_n_res=1.
- PRE, 1 cycle: dut_d=1. Leaving edge checks dut_q==1.
- ASSERT, RST_CYCLES cycles: dut_n_res=0, dut_d=1, so D is held high against the reset. The edge leaving the last ASSERT cycle checks dut_q==0.
- RELEASE, 1 cycle: dut_n_res=1, dut_d=0.
- DONE, 1 cycle: done=1, busy=1. Counters are frozen until the next accepted start. Next state is IDLE.
- Counters saturate at 2^CNT_W-1 and never wrap.
- start outside IDLE is ignored, including in DONE.
- n_res low at any time forces all reset values immediately and aborts the run with no done pulse. dut_n_res returns to 1 asynchronously.
- Checks per run: NUM_VECTORS+2 with the macro, NUM_VECTORS without it.

## Timing
- Registered outputs change only on the rising edge of CLK, or asynchronously on n_res.
- 2 cycles per vector. The DUT has one full cycle of clock-to-Q before dut_q is sampled.
- Accepting edge to DONE entry:
  - with macro: 2*NUM_VECTORS+RST_CYCLES+3 cycles (21 for defaults);
  - without macro: 2*NUM_VECTORS cycles (16).
- busy rises on the accepting edge and falls on the edge leaving DONE.
- Back-to-back runs: start held high through DONE is accepted in the following IDLE cycle. Minimum gap is 1 IDLE cycle.

## Configuration
- DFF_BIST_RESET_TEST_EN defined: ARM/PRE/ASSERT/RELEASE states exist, and the reset phase runs after the data vectors.
- Undefined: those states are compiled out, SAMPLE of the last vector goes straight to DONE, dut_n_res is constant 1 after reset release, and RST_CYCLES is unused.

## Test plan
- Healthy behavioural DFF, defaults, macro on, start pulse -> done exactly 21 cycles after the accepting edge; pass_cnt=10, fail_cnt=0.
- Same DUT, macro off -> done after 16 cycles; pass_cnt=8, fail_cnt=0; dut_n_res never low.
- DUT whose Q ignores its reset (macro on) -> pass_cnt=9, fail_cnt=1, with the failure recorded at the ASSERT check.
- Stuck-at-1 DUT (macro on) -> fail_cnt = number of 0 bits in the 8 driven LFSR bits (from a bench reference LFSR) + 1; pass_cnt = 10 - fail_cnt.
- n_res pulsed low mid-run, during SAMPLE of vector 4 -> immediate reset values; no done pulse. A new start then gives the full healthy result of 10/0.
- start re-asserted while busy, and SEED=0 -> extra start ignored; run uses seed 8'h01; results still 10/0.

Source files
------------

// File: rtl/dff_bist.sv
// dff_bist: BIST initiator for one D flip-flop cell; drives D and reset, samples Q, tallies pass/fail.
// Define DFF_BIST_RESET_TEST_EN to add the ARM/PRE/ASSERT/RELEASE reset-phase checks.
module dff_bist #(
   parameter int unsigned NUM_VECTORS = 8,
   parameter int unsigned RST_CYCLES  = 2,
   parameter logic [7:0]  SEED        = 8'hA5,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             CLK,
   input  logic             n_res,
   input  logic             start,
   input  logic             dut_q,
   output logic             dut_d,
   output logic             dut_n_res,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt
);
   localparam int unsigned IDX_W    = 8;
   localparam logic [7:0]  SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

   if (NUM_VECTORS < 1 || NUM_VECTORS > 255 || RST_CYCLES < 1 || CNT_W < 1) begin : g_param_check
      $error("dff_bist: illegal parameter value");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SAMPLE,
`ifdef DFF_BIST_RESET_TEST_EN
      ST_ARM,
      ST_PRE,
      ST_ASSERT,
      ST_RELEASE,
`endif
      ST_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [7:0]       lfsr_q, lfsr_d;
   logic [7:0]       lfsr_nxt;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] pass_q, pass_d;
   logic [CNT_W-1:0] fail_q, fail_d;
   logic             d_out_q, d_out_d;
   logic             nres_out_q, nres_out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             chk_en, chk_ok;

`ifdef DFF_BIST_RESET_TEST_EN
   localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
`endif

   assign lfsr_nxt = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

   // Next-state, next-output and check-strobe logic
   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      idx_d      = idx_q;
      pass_d     = pass_q;
      fail_d     = fail_q;
      d_out_d    = d_out_q;
      nres_out_d = 1'b1;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      chk_en     = 1'b0;
      chk_ok     = 1'b0;
`ifdef DFF_BIST_RESET_TEST_EN
      rst_cnt_d  = rst_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               state_d = ST_DRIVE;
               busy_d  = 1'b1;
               lfsr_d  = SEED_EFF;
               idx_d   = '0;
               pass_d  = '0;
               fail_d  = '0;
               d_out_d = SEED_EFF[0];
            end
         end
         ST_DRIVE: state_d = ST_SAMPLE;
         ST_SAMPLE: begin
            chk_en = 1'b1;
            chk_ok = (dut_q == lfsr_q[0]);
            lfsr_d = lfsr_nxt;
            if (idx_q < IDX_W'(NUM_VECTORS - 1)) begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = ST_DRIVE;
               d_out_d = lfsr_nxt[0];
            end else begin
`ifdef DFF_BIST_RESET_TEST_EN
               state_d = ST_ARM;
               d_out_d = 1'b1;
`else
               state_d = ST_DONE;
               done_d  = 1'b1;
`endif
            end
         end
`ifdef DFF_BIST_RESET_TEST_EN
         ST_ARM: state_d = ST_PRE;
         ST_PRE: begin
            chk_en     = 1'b1;
            chk_ok     = dut_q;
            state_d    = ST_ASSERT;
            nres_out_d = 1'b0;
            rst_cnt_d  = '0;
         end
         // D stays high while reset is held, so a Q of 0 proves the reset won
         ST_ASSERT: begin
            if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
               chk_en  = 1'b1;
               chk_ok  = ~dut_q;
               state_d = ST_RELEASE;
               d_out_d = 1'b0;
            end else begin
               nres_out_d = 1'b0;
               rst_cnt_d  = rst_cnt_q + RC_W'(1);
            end
         end
         ST_RELEASE: begin
            state_d = ST_DONE;
            done_d  = 1'b1;
         end
`endif
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // Saturating tallies
      if (chk_en) begin
         if (chk_ok) begin
            if (pass_q != {CNT_W{1'b1}}) pass_d = pass_q + CNT_W'(1);
         end else begin
            if (fail_q != {CNT_W{1'b1}}) fail_d = fail_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge n_res) begin
      if (!n_res) begin
         state_q    <= ST_IDLE;
         lfsr_q     <= SEED_EFF;
         idx_q      <= '0;
         pass_q     <= '0;
         fail_q     <= '0;
         d_out_q    <= 1'b0;
         nres_out_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef DFF_BIST_RESET_TEST_EN
         rst_cnt_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         idx_q      <= idx_d;
         pass_q     <= pass_d;
         fail_q     <= fail_d;
         d_out_q    <= d_out_d;
         nres_out_q <= nres_out_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef DFF_BIST_RESET_TEST_EN
         rst_cnt_q  <= rst_cnt_d;
`endif
      end
   end

   assign dut_d     = d_out_q;
   assign dut_n_res = nres_out_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass_cnt  = pass_q;
   assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_dff_bist.sv
// tb_dff_bist: randomized scoreboard bench for dff_bist driving behavioural flip-flops
// (healthy, reset-ignoring, stuck-at-1); one default instance and one SEED=0 / narrow-counter instance.
module tb_dff_bist;
   localparam int unsigned NV_A = 8;
   localparam int unsigned RC_A = 2;
   localparam int unsigned CW_A = 8;
   localparam logic [7:0]  SEED_A = 8'hA5;
   localparam int unsigned NV_B = 9;
   localparam int unsigned RC_B = 3;
   localparam int unsigned CW_B = 3;
   localparam logic [7:0]  SEED_B = 8'h00;
`ifdef DFF_BIST_RESET_TEST_EN
   localparam bit RT_EN = 1'b1;
`else
   localparam bit RT_EN = 1'b0;
`endif
   localparam int M_OK    = 0;
   localparam int M_IGN   = 1;
   localparam int M_STUCK = 2;

   typedef struct {
      int unsigned pass_n;
      int unsigned fail_n;
      int          cyc;
   } exp_t;

   logic clk   = 1'b0;
   logic n_res = 1'b1;
   logic a_start = 1'b0, b_start = 1'b0;
   logic a_q, a_d, a_nres, a_busy, a_done, a_ff;
   logic b_q, b_d, b_nres, b_busy, b_done, b_ff;
   logic [CW_A-1:0] a_pass, a_fail;
   logic [CW_B-1:0] b_pass, b_fail;
   int mode_a = 0, mode_b = 0;
   int cyc = 0;
   int low_a = 0, exp_low_a = 0;
   int n_tests = 0, n_fail = 0;
   exp_t qa[$], qb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (a_nres === 1'b0) low_a <= low_a + 1;

   dff_bist u_a (
      .CLK(clk), .n_res(n_res), .start(a_start), .dut_q(a_q), .dut_d(a_d), .dut_n_res(a_nres),
      .busy(a_busy), .done(a_done), .pass_cnt(a_pass), .fail_cnt(a_fail)
   );

   dff_bist #(.NUM_VECTORS(NV_B), .RST_CYCLES(RC_B), .SEED(SEED_B), .CNT_W(CW_B)) u_b (
      .CLK(clk), .n_res(n_res), .start(b_start), .dut_q(b_q), .dut_d(b_d), .dut_n_res(b_nres),
      .busy(b_busy), .done(b_done), .pass_cnt(b_pass), .fail_cnt(b_fail)
   );

   // Cells under test; a reset-ignoring cell simply keeps its value while reset is low
   always @(posedge clk or negedge a_nres) begin
      if (!a_nres) begin
         if (mode_a != M_IGN) a_ff <= 1'b0;
      end else a_ff <= a_d;
   end
   always @(posedge clk or negedge b_nres) begin
      if (!b_nres) begin
         if (mode_b != M_IGN) b_ff <= 1'b0;
      end else b_ff <= b_d;
   end
   assign a_q = (mode_a == M_STUCK) ? 1'b1 : a_ff;
   assign b_q = (mode_b == M_STUCK) ? 1'b1 : b_ff;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int lat(input int unsigned nv, input int unsigned rc);
      return 2 * int'(nv) + (RT_EN ? int'(rc) + 3 : 0);
   endfunction

   // Reference: walk the pseudo-random sequence, predict what each kind of cell returns
   function automatic exp_t model(input int unsigned nv, input logic [7:0] seed, input int mode,
                                  input int unsigned cw);
      exp_t e;
      int unsigned l, p, f, mx;
      bit want, got;
      l = (seed == 8'h00) ? 1 : int'(seed);
      p = 0;
      f = 0;
      for (int i = 0; i < int'(nv); i++) begin
         want = (l % 2) == 1;
         got  = (mode == M_STUCK) ? 1'b1 : want;
         if (got == want) p++; else f++;
         l = ((l * 2) % 256) + ($countones(8'(l) & 8'hB8) % 2);
      end
      if (RT_EN) begin
         p++;
         if (mode == M_OK) p++; else f++;
      end
      mx = (1 << cw) - 1;
      e.pass_n = (p > mx) ? mx : p;
      e.fail_n = (f > mx) ? mx : f;
      e.cyc    = 0;
      return e;
   endfunction

   task automatic mon_a();
      exp_t e;
      forever begin
         @(negedge clk);
         if (a_done === 1'b1) begin
            check("a_done_expected", longint'(qa.size() > 0), 1);
            if (qa.size() > 0) begin
               e = qa.pop_front();
               check("a_done_cycle", cyc, e.cyc);
               check("a_pass_cnt", a_pass, e.pass_n);
               check("a_fail_cnt", a_fail, e.fail_n);
               check("a_busy_in_done", a_busy, 1);
            end
         end
      end
   endtask

   task automatic mon_b();
      exp_t e;
      forever begin
         @(negedge clk);
         if (b_done === 1'b1) begin
            check("b_done_expected", longint'(qb.size() > 0), 1);
            if (qb.size() > 0) begin
               e = qb.pop_front();
               check("b_done_cycle", cyc, e.cyc);
               check("b_pass_cnt", b_pass, e.pass_n);
               check("b_fail_cnt", b_fail, e.fail_n);
            end
         end
      end
   endtask

   task automatic launch_a(input int mode, input bit push);
      exp_t e;
      @(negedge clk);
      mode_a  = mode;
      a_start = 1'b1;
      if (push) begin
         e     = model(NV_A, SEED_A, mode, CW_A);
         e.cyc = cyc + 1 + lat(NV_A, RC_A);
         qa.push_back(e);
         exp_low_a += RT_EN ? int'(RC_A) : 0;
      end
      @(negedge clk);
      check("a_busy_after_accept", a_busy, 1);
      a_start = 1'b0;
   endtask

   task automatic launch_b(input int mode);
      exp_t e;
      @(negedge clk);
      mode_b  = mode;
      b_start = 1'b1;
      e       = model(NV_B, SEED_B, mode, CW_B);
      e.cyc   = cyc + 1 + lat(NV_B, RC_B);
      qb.push_back(e);
      @(negedge clk);
      check("b_busy_after_accept", b_busy, 1);
      b_start = 1'b0;
   endtask

   task automatic wait_a();
      int n = 0;
      while (qa.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("a_runs_outstanding", qa.size(), 0);
      qa.delete();
      @(negedge clk);
   endtask

   task automatic wait_b();
      int n = 0;
      while (qb.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("b_runs_outstanding", qb.size(), 0);
      qb.delete();
      @(negedge clk);
   endtask

   initial begin
      exp_t e1, e2;
      fork
         mon_a();
         mon_b();
      join_none

      #2 n_res = 1'b0;
      #1;
      check("rst_a_busy", a_busy, 0);
      check("rst_a_done", a_done, 0);
      check("rst_a_pass", a_pass, 0);
      check("rst_a_fail", a_fail, 0);
      check("rst_a_dut_d", a_d, 0);
      check("rst_a_dut_n_res", a_nres, 1);
      check("rst_b_busy", b_busy, 0);
      repeat (2) @(negedge clk);
      n_res = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_a_busy", a_busy, 0);

      // Directed runs on the default instance
      launch_a(M_OK, 1'b1);    wait_a();
      launch_a(M_IGN, 1'b1);   wait_a();
      launch_a(M_STUCK, 1'b1); wait_a();

      // start held high through DONE: next run accepted after one IDLE cycle
      @(negedge clk);
      mode_a  = M_OK;
      a_start = 1'b1;
      e1      = model(NV_A, SEED_A, M_OK, CW_A);
      e1.cyc  = cyc + 1 + lat(NV_A, RC_A);
      e2      = e1;
      e2.cyc  = e1.cyc + 2 + lat(NV_A, RC_A);
      qa.push_back(e1);
      qa.push_back(e2);
      exp_low_a += RT_EN ? 2 * int'(RC_A) : 0;
      repeat (lat(NV_A, RC_A) + 3) @(negedge clk);
      a_start = 1'b0;
      wait_a();

      // Abort in SAMPLE of vector 4
      launch_a(M_OK, 1'b0);
      repeat (9) @(negedge clk);
      check("abort_pass_before", a_pass, 4);
      n_res = 1'b0;
      #1;
      check("abort_busy", a_busy, 0);
      check("abort_done", a_done, 0);
      check("abort_pass", a_pass, 0);
      check("abort_fail", a_fail, 0);
      check("abort_dut_n_res", a_nres, 1);
      check("abort_dut_d", a_d, 0);
      @(negedge clk);
      n_res = 1'b1;
      repeat (30) @(negedge clk);
      check("abort_stays_idle", a_busy, 0);
      launch_a(M_OK, 1'b1); wait_a();

      // SEED=0 instance with extra start pulses while busy
      launch_b(M_OK);
      repeat (5) @(negedge clk);
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      wait_b();
      launch_b(M_STUCK);
      repeat (3) @(negedge clk);
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      wait_b();

      // Randomized runs on both instances
      for (int r = 0; r < 8; r++) begin
         launch_a(int'($urandom_range(0, 2)), 1'b1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         launch_b(int'($urandom_range(0, 2)));
         if ($urandom_range(0, 1) == 1) begin
            a_start = 1'b1;
            @(negedge clk);
            a_start = 1'b0;
         end
         wait_a();
         wait_b();
      end

      check("a_dut_n_res_low_cycles", low_a, exp_low_a);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
